io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter BASE, default 8'hF0: data-bus address of the TX data register; the status register is at BASE+1.
REQ-003 Parameter DEPTH, default 4: TX FIFO entries; power of two.
REQ-004 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port addr, input, 8: CPU data-bus address, driven from the CPU's rs operand.
REQ-007 Port w_data, input, 8: CPU store data, driven from the CPU's rd operand.
REQ-008 Port w_en, input, 1: CPU store strobe; one cycle per store.
REQ-009 Port r_data, output, 8: load data returned to the CPU.
REQ-010 Port tx, output, 1: serial line, idle high, registered.

Function
REQ-011 A store (w_en=1, addr=BASE) with the FIFO not full SHALL push w_data into the FIFO at that edge.
REQ-012 A store to BASE with the FIFO full SHALL be dropped and SHALL set the sticky overflow flag.
REQ-013 A store to BASE+1 SHALL clear overflow; its w_data is ignored.
REQ-014 r_data SHALL be combinational from addr and state:
- addr = BASE+1: {4'b0, overflow, busy, empty, full}
- any other address: 8'h00
REQ-015 busy SHALL be 1 whenever state != IDLE.
REQ-016 The frame format SHALL be 8N1: start bit 0, eight data bits LSB first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE: at an edge where the FIFO is non-empty, pop the head into the shift register, load the bit counter with 0, set tx<=0 and go to START; the baud counter restarts at 0.
REQ-019 START: after CLK_DIV cycles, set tx<=bit0 and go to DATA.
REQ-020 DATA: every CLK_DIV cycles, shift out the next bit; after bit7 has lasted CLK_DIV cycles, set tx<=1 and go to STOP.
REQ-021 STOP: after CLK_DIV cycles, either start the next frame directly if the FIFO is non-empty (tx<=0, pop, go to START, no idle gap), or go to IDLE.
REQ-022 Latency: a store to an empty FIFO while IDLE at edge N SHALL drive tx low from edge N+1.
REQ-023 A push and a pop at the same edge SHALL both take effect, including when the FIFO is full (count unchanged, no overflow).
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from an occupancy count of width log2(DEPTH)+1.
REQ-025 Stores and loads to other addresses SHALL have no effect on the block.

Reset
REQ-026 While reset=1 at an edge:
- state <= IDLE, tx <= 1
- FIFO emptied, overflow <= 0
- baud and bit counters <= 0
REQ-027 Reset mid-frame SHALL abort the frame, with tx high on the following cycle.
REQ-028 When reset and w_en are high at the same edge, reset SHALL win and the store SHALL be lost.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the register offsets (TX=0, STAT=1) and the status bit positions.
REQ-030 The FIFO SHALL be a sub-module named tx_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty).
REQ-031 The top level SHALL instantiate io_uart_tx on the same addr/w_data/w_en bus as data_mem, with r_data muxed by address.

Verification (CLK_DIV=4, DEPTH=4)
REQ-032 Store 8'hA5 to F0 while idle: tx low from the next edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; status reads 8'h02 afterwards.
REQ-033 Five back-to-back stores (11, 22, 33, 44, 55): one is popped immediately, so all five are accepted with no overflow; five contiguous frames with no idle gap; status shows busy throughout.
REQ-034 Six stores while idle: the sixth is dropped, status reads 8'h0D (overflow, busy, full), and only five frames are emitted; storing to F1 then clears bit 3.
REQ-035 Assert reset during DATA bit 3: tx=1 the next cycle, status 8'h02, and no further frames are emitted.
REQ-036 Load from F1 during a STOP that chains to the next frame: busy=1 with no idle cycle; a load from 8'h10 returns 8'h00.

Source files
------------

// File: rtl/io_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// io_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//     - tx_state_e     : transmit FSM state encoding
//     - REG_TX/REG_STAT: register offsets relative to the block base address
//     - STAT_*         : bit positions inside the status register
//     - pack_status()  : assembles the status byte from its flags
// -----------------------------------------------------------------------------
package io_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Register offsets from BASE.
    localparam logic [7:0] REG_TX   = 8'd0;
    localparam logic [7:0] REG_STAT = 8'd1;

    // Status register bit positions.
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // Status byte layout: {4'b0, overflow, busy, empty, full}.
    function automatic logic [7:0] pack_status(
        input logic ovf,
        input logic busy,
        input logic empty,
        input logic full
    );
        logic [7:0] s;
        s              = 8'h00;
        s[STAT_OVF]    = ovf;
        s[STAT_BUSY]   = busy;
        s[STAT_EMPTY]  = empty;
        s[STAT_FULL]   = full;
        return s;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
//   Small synchronous FIFO holding bytes waiting to be serialised.
//   Pointers wrap modulo DEPTH; full/empty come from an occupancy count that is
//   one bit wider than the pointers. A push and a pop at the same edge both take
//   effect, even when the FIFO is full.
//
// Parameters
//   WIDTH : data width in bits
//   DEPTH : number of entries, power of two, at least 2
//
// Ports
//   clock : system clock, rising edge
//   reset : synchronous active-high reset, empties the FIFO
//   push  : write din at this edge (ignored when full unless popping too)
//   pop   : advance the read pointer at this edge (ignored when empty)
//   din   : write data
//   dout  : head entry, valid while empty is low
//   full  : occupancy equals DEPTH
//   empty : occupancy is zero
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot the push needs, so a full FIFO still accepts a
    // write when it is being read at the same edge.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observable after
    // a push, and leaving it unreset lets it map onto plain RAM/register cells.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// -----------------------------------------------------------------------------
// io_uart_tx
//   Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//   A store to BASE queues a byte; a store to BASE+1 clears the sticky overflow
//   flag. Loads from BASE+1 return {4'b0, overflow, busy, empty, full}; every
//   other address reads as zero. Frames are sent back to back while the FIFO
//   holds data, with no idle bit between them.
//
// Parameters
//   CLK_DIV : clock cycles per serial bit, 2..255
//   BASE    : address of the TX data register (status at BASE+1)
//   DEPTH   : FIFO entries, power of two
//
// Ports
//   clock  : system clock, rising edge
//   reset  : synchronous active-high reset
//   addr   : CPU data-bus address
//   w_data : CPU store data
//   w_en   : CPU store strobe, one cycle per store
//   r_data : combinational load data
//   tx     : registered serial output, idle high
// -----------------------------------------------------------------------------
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int         CLK_DIV = 16,
    parameter logic [7:0] BASE    = 8'hF0,
    parameter int         DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] w_data,
    input  logic       w_en,
    output logic [7:0] r_data,
    output logic       tx
);

    localparam logic [7:0] ADDR_TX   = BASE + REG_TX;
    localparam logic [7:0] ADDR_STAT = BASE + REG_STAT;
    localparam logic [7:0] BAUD_LAST = 8'(CLK_DIV - 1);

    // Registered state.
    tx_state_e  r_state;
    logic [7:0] r_baud;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_tx;
    logic       r_overflow;

    // Next-state values from the FSM.
    tx_state_e  w_state_next;
    logic [7:0] w_baud_next;
    logic [2:0] w_bit_next;
    logic [7:0] w_shift_next;
    logic       w_tx_next;
    logic       w_pop;

    // Bus decode and FIFO interface.
    logic       w_store_tx;
    logic       w_store_stat;
    logic       w_baud_done;
    logic       w_busy;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_dout;

    assign w_store_tx   = w_en && (addr == ADDR_TX);
    assign w_store_stat = w_en && (addr == ADDR_STAT);
    assign w_baud_done  = (r_baud == BAUD_LAST);
    assign w_busy       = (r_state != ST_IDLE);

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_store_tx),
        .pop   (w_pop),
        .din   (w_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // -------------------------------------------------------------------------
    // Transmit FSM, next-state logic.
    // The shift register always holds the current data bit in position 0, so
    // the bit that follows it is r_shift[1] just before the shift.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_dout;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b0;
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end

            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                        w_bit_next   = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end

            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (!w_empty) begin
                        // Chain straight into the next start bit.
                        w_pop        = 1'b1;
                        w_shift_next = w_dout;
                        w_bit_next   = '0;
                        w_tx_next    = 1'b0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 8'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_baud_next  = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // Sticky overflow: set by a store that finds the FIFO full with no pop in
    // the same edge, cleared by any store to the status register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_store_stat) begin
            r_overflow <= 1'b0;
        end else if (w_store_tx && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    assign tx     = r_tx;
    assign r_data = (addr == ADDR_STAT) ? pack_status(r_overflow, w_busy, w_empty, w_full)
                                        : 8'h00;

endmodule

// File: tb/tb_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_tx
//   Self-checking bench for io_uart_tx with CLK_DIV=4, DEPTH=4, BASE=F0.
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_io_uart_tx;

    localparam int         CLK_DIV = 4;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] BASE    = 8'hF0;

    logic       clock;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    io_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .BASE    (BASE),
        .DEPTH   (DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .addr   (addr),
        .w_data (w_data),
        .w_en   (w_en),
        .r_data (r_data),
        .tx     (tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_tx;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit k of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Called at +1 after an edge; the store lands on the next edge.
    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        w_data = d;
        w_en   = 1'b1;
        @(posedge clock);
        #1;
        w_en   = 1'b0;
    endtask

    // Samples tx for one full frame, CLK_DIV samples per bit.
    task automatic check_frame(input logic [7:0] b, input logic chk_busy, input string tag);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(posedge clock);
                #1;
                check($sformatf("%s tx bit%0d cyc%0d", tag, k, c), {7'b0, tx}, {7'b0, frame_bit(b, k)});
                if (chk_busy) begin
                    check($sformatf("%s busy bit%0d cyc%0d", tag, k, c), {7'b0, r_data[2]}, 8'h01);
                end
            end
        end
    endtask

    task automatic check_idle_line(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s tx idle cyc%0d", tag, i), {7'b0, tx}, 8'h01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 8'hF1, we: 1'b0, wd: 8'h00, exp_rd: 8'h02, exp_tx: 1'b1};
        vecs[1] = '{addr: 8'hF0, we: 1'b0, wd: 8'h00, exp_rd: 8'h00, exp_tx: 1'b1};
        vecs[2] = '{addr: 8'h10, we: 1'b0, wd: 8'h00, exp_rd: 8'h00, exp_tx: 1'b1};
        vecs[3] = '{addr: 8'h10, we: 1'b1, wd: 8'hFF, exp_rd: 8'h00, exp_tx: 1'b1};
        vecs[4] = '{addr: 8'hF2, we: 1'b1, wd: 8'hAA, exp_rd: 8'h00, exp_tx: 1'b1};
        vecs[5] = '{addr: 8'hEF, we: 1'b1, wd: 8'h55, exp_rd: 8'h00, exp_tx: 1'b1};
        vecs[6] = '{addr: 8'hF1, we: 1'b1, wd: 8'hFF, exp_rd: 8'h02, exp_tx: 1'b1};
        vecs[7] = '{addr: 8'h00, we: 1'b1, wd: 8'h01, exp_rd: 8'h00, exp_tx: 1'b1};

        reset  = 1'b1;
        addr   = 8'hF1;
        w_data = 8'h00;
        w_en   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset tx", {7'b0, tx}, 8'h01);
        check("reset status", r_data, 8'h02);

        // ---- Table: loads and stores that must not disturb the block ----
        for (int i = 0; i < 8; i++) begin
            addr   = vecs[i].addr;
            w_en   = vecs[i].we;
            w_data = vecs[i].wd;
            #1;
            check($sformatf("vec%0d r_data", i), r_data, vecs[i].exp_rd);
            @(posedge clock);
            #1;
            w_en = 1'b0;
            check($sformatf("vec%0d tx", i), {7'b0, tx}, {7'b0, vecs[i].exp_tx});
        end
        addr = 8'hF1;
        check_idle_line(3, "post-table");
        check("post-table status", r_data, 8'h02);

        // ---- Single frame A5, latency and bit timing ----
        do_store(8'hF0, 8'hA5);
        addr = 8'hF1;
        check("A5 tx at store edge", {7'b0, tx}, 8'h01);
        check_frame(8'hA5, 1'b1, "A5");
        @(posedge clock);
        #1;
        check("A5 status after", r_data, 8'h02);

        // ---- Five back-to-back stores, five contiguous frames ----
        fork
            begin
                do_store(8'hF0, 8'h11);
                do_store(8'hF0, 8'h22);
                do_store(8'hF0, 8'h33);
                do_store(8'hF0, 8'h44);
                do_store(8'hF0, 8'h55);
                addr = 8'hF1;
                #1;
                check("five stores status", r_data, 8'h05);
                addr = 8'h10;
                #1;
                check("load 10 while busy", r_data, 8'h00);
                addr = 8'hF1;
            end
            begin
                @(posedge clock);
                #1;
                check("five tx at store edge", {7'b0, tx}, 8'h01);
                check_frame(8'h11, 1'b0, "f11");
                check_frame(8'h22, 1'b1, "f22");
                check_frame(8'h33, 1'b1, "f33");
                check_frame(8'h44, 1'b1, "f44");
                check_frame(8'h55, 1'b1, "f55");
            end
        join
        @(posedge clock);
        #1;
        check("five status after", r_data, 8'h02);

        // ---- Six stores: sixth dropped, overflow set then cleared ----
        fork
            begin
                do_store(8'hF0, 8'h81);
                do_store(8'hF0, 8'h42);
                do_store(8'hF0, 8'hC3);
                do_store(8'hF0, 8'h24);
                do_store(8'hF0, 8'hE5);
                do_store(8'hF0, 8'h66);
                addr = 8'hF1;
                #1;
                check("six stores status", r_data, 8'h0D);
                do_store(8'hF1, 8'hFF);
                #1;
                check("overflow cleared status", r_data, 8'h05);
            end
            begin
                @(posedge clock);
                #1;
                check("six tx at store edge", {7'b0, tx}, 8'h01);
                check_frame(8'h81, 1'b0, "f81");
                check_frame(8'h42, 1'b1, "f42");
                check_frame(8'hC3, 1'b1, "fC3");
                check_frame(8'h24, 1'b1, "f24");
                check_frame(8'hE5, 1'b1, "fE5");
            end
        join
        @(posedge clock);
        #1;
        check("six status after", r_data, 8'h02);
        check_idle_line(44, "no sixth frame");

        // ---- Reset during DATA bit 3, with a store colliding with reset ----
        fork
            begin
                do_store(8'hF0, 8'h3C);
                do_store(8'hF0, 8'h5A);
                do_store(8'hF0, 8'h96);
                addr = 8'hF1;
            end
            begin
                @(posedge clock);
                #1;
                check("rst tx at store edge", {7'b0, tx}, 8'h01);
                for (int s = 0; s < 18; s++) begin
                    @(posedge clock);
                    #1;
                    check($sformatf("f3C sample%0d", s), {7'b0, tx}, {7'b0, frame_bit(8'h3C, s / CLK_DIV)});
                end
            end
        join
        reset  = 1'b1;
        addr   = 8'hF0;
        w_data = 8'h77;
        w_en   = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        w_en  = 1'b0;
        addr  = 8'hF1;
        check("mid-frame reset tx", {7'b0, tx}, 8'h01);
        #1;
        check("mid-frame reset status", r_data, 8'h02);
        check_idle_line(60, "after reset");
        check("after reset status", r_data, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
